button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 194 +++++++++++++++++++
 tb/tb_button_conditioner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Conditions two asynchronous pushbuttons (up/down) into clean, registered
//   one-cycle step pulses for a downstream up/down counter FSM. Each raw input
//   is synchronized with two flops and normalized so that 1 means "pressed".
//   A per-channel IDLE/PRESS/REPEAT FSM emits one pulse per fresh press and,
//   optionally, auto-repeat pulses while the button stays held.
//
// Configuration:
//   BUTTON_AUTOREPEAT_EN - when defined, enables the REPEAT state: after
//   HOLD_DELAY cycles of continuous press a pulse is emitted and the channel
//   then pulses every REPEAT_PERIOD cycles. When undefined, a press gives
//   exactly one pulse, REPEAT is unreachable, hold is constant 0 and the
//   HOLD_DELAY/REPEAT_PERIOD parameters have no effect.
//
// Parameters:
//   ACTIVE_LOW    - 1: raw buttons read 0 when pressed; 0: read 1 when pressed
//   HOLD_DELAY    - cycles of continuous press before auto-repeat (1..15)
//   REPEAT_PERIOD - cycles between auto-repeat pulses (1..15)
//
// Ports:
//   clk1hz   in  block clock, all state updates on its rising edge
//   reset    in  synchronous, active-high reset
//   up_raw   in  asynchronous up pushbutton
//   down_raw in  asynchronous down pushbutton
//   up       out registered step-up pulse
//   down     out registered step-down pulse
//   hold     out registered, high while either channel is in REPEAT
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int ACTIVE_LOW    = 1,
    parameter int HOLD_DELAY    = 3,
    parameter int REPEAT_PERIOD = 1
) (
    input  logic clk1hz,
    input  logic reset,
    input  logic up_raw,
    input  logic down_raw,
    output logic up,
    output logic down,
    output logic hold
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Raw level of a button that is not pressed.
    localparam logic releasedLevel = (ACTIVE_LOW != 0);

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [3:0] holdLimit   = 4'(HOLD_DELAY);
    localparam logic [3:0] repeatLimit = 4'(REPEAT_PERIOD);
`else
    logic unusedParams;
    assign unusedParams = ^{HOLD_DELAY, REPEAT_PERIOD};
`endif

    // Channel 0 is up, channel 1 is down.
    logic [1:0] rawBtn;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] level;

    state_t     state_q [2];
    state_t     state_d [2];
    logic [3:0] cnt_q   [2];
    logic [3:0] cnt_d   [2];
    logic [1:0] pulse_q;
    logic [1:0] pulse_d;
    logic       hold_q;
    logic       hold_d;

    assign rawBtn = {down_raw, up_raw};

    // Normalize to 1 = pressed after synchronization.
    assign level = releasedLevel ? ~sync2_q : sync2_q;

    // Counter increment that sticks at 15 instead of wrapping.
    function automatic logic [3:0] satInc(input logic [3:0] value);
        return (value == 4'd15) ? 4'd15 : value + 4'd1;
    endfunction

    // Two-flop synchronizer per channel. Reset loads the released level so
    // a button held through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk1hz) begin
        if (reset) begin
            sync1_q <= {2{releasedLevel}};
            sync2_q <= {2{releasedLevel}};
        end else begin
            sync1_q <= rawBtn;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and output registers. Reset clears the pulses in the
    // same edge, cancelling any press or repeat in progress.
    always_ff @(posedge clk1hz) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= IDLE;
                cnt_q[ch]   <= 4'd0;
            end
            pulse_q <= 2'b00;
            hold_q  <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            pulse_q <= pulse_d;
            hold_q  <= hold_d;
        end
    end

    // Per-channel next-state logic. The counter comparisons use the
    // incremented value so that a pulse lands exactly HOLD_DELAY (or
    // REPEAT_PERIOD) cycles after the previous one.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            pulse_d[ch] = 1'b0;

            case (state_q[ch])
                IDLE: begin
                    if (level[ch]) begin
                        state_d[ch] = PRESS;
                        cnt_d[ch]   = 4'd0;
                        pulse_d[ch] = 1'b1;
                    end
                end

                PRESS: begin
                    if (!level[ch]) begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = 4'd0;
                    end else begin
`ifdef BUTTON_AUTOREPEAT_EN
                        if (satInc(cnt_q[ch]) == holdLimit) begin
                            state_d[ch] = REPEAT;
                            cnt_d[ch]   = 4'd0;
                            pulse_d[ch] = 1'b1;
                        end else begin
                            cnt_d[ch] = satInc(cnt_q[ch]);
                        end
`else
                        cnt_d[ch] = satInc(cnt_q[ch]);
`endif
                    end
                end

                REPEAT: begin
`ifdef BUTTON_AUTOREPEAT_EN
                    if (!level[ch]) begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = 4'd0;
                    end else if (satInc(cnt_q[ch]) == repeatLimit) begin
                        cnt_d[ch]   = 4'd0;
                        pulse_d[ch] = 1'b1;
                    end else begin
                        cnt_d[ch] = satInc(cnt_q[ch]);
                    end
`else
                    state_d[ch] = IDLE;
                    cnt_d[ch]   = 4'd0;
`endif
                end

                default: begin
                    state_d[ch] = IDLE;
                    cnt_d[ch]   = 4'd0;
                end
            endcase
        end
    end

    // hold follows the registered REPEAT membership of either channel.
    always_comb begin
        hold_d = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        hold_d = (state_d[0] == REPEAT) || (state_d[1] == REPEAT);
`endif
    end

    assign up   = pulse_q[0];
    assign down = pulse_q[1];
    assign hold = hold_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Drives two conditioner instances from a shared clock and reset:
//   dutA: ACTIVE_LOW=1, HOLD_DELAY=3, REPEAT_PERIOD=2
//   dutB: ACTIVE_LOW=0, HOLD_DELAY=2, REPEAT_PERIOD=1
// The reference model tracks, per channel, how many consecutive cycles the
// FSM has seen the button pressed (run length) and derives pulses and hold
// from that number arithmetically.
// Model channel index: 0 = A.up, 1 = A.down, 2 = B.up, 3 = B.down.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    logic clk1hz   = 1'b0;
    logic reset    = 1'b1;
    logic upRawA   = 1'b1;
    logic downRawA = 1'b1;
    logic upRawB   = 1'b0;
    logic downRawB = 1'b0;
    logic upA, downA, holdA;
    logic upB, downB, holdB;

    int checkCount = 0;
    int passCount  = 0;

    int   runLen  [4] = '{0, 0, 0, 0};
    logic seen1   [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic seen2   [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int   holdP   [4] = '{3, 3, 2, 2};
    int   repP    [4] = '{2, 2, 1, 1};
    logic [2:0] expA = 3'b000;
    logic [2:0] expB = 3'b000;

    button_conditioner #(.ACTIVE_LOW(1), .HOLD_DELAY(3), .REPEAT_PERIOD(2)) dutA (
        .clk1hz  (clk1hz),
        .reset   (reset),
        .up_raw  (upRawA),
        .down_raw(downRawA),
        .up      (upA),
        .down    (downA),
        .hold    (holdA)
    );

    button_conditioner #(.ACTIVE_LOW(0), .HOLD_DELAY(2), .REPEAT_PERIOD(1)) dutB (
        .clk1hz  (clk1hz),
        .reset   (reset),
        .up_raw  (upRawB),
        .down_raw(downRawB),
        .up      (upB),
        .down    (downB),
        .hold    (holdB)
    );

    always #5 clk1hz = ~clk1hz;

`ifdef BUTTON_AUTOREPEAT_EN
    // Pulse on the first pressed cycle, then HOLD_DELAY cycles later, then
    // every REPEAT_PERIOD cycles.
    function automatic logic expPulse(input int n, input int h, input int r);
        if (n == 1) return 1'b1;
        if (n >= 1 + h && ((n - 1 - h) % r) == 0) return 1'b1;
        return 1'b0;
    endfunction
`else
    function automatic logic expPulse(input int n);
        return (n == 1);
    endfunction
`endif

    // Apply one cycle of logical presses (1 = pressed) and reset, advance the
    // model across the rising edge and leave expectations in expA/expB.
    // The FSM sees a press two edges after it is sampled; reset edges
    // sample nothing.
    task automatic applyStimulus(input logic [3:0] press, input logic rst);
        logic [3:0] pulse;
        logic [1:0] inRepeat;
        @(negedge clk1hz);
        reset    = rst;
        upRawA   = ~press[0];
        downRawA = ~press[1];
        upRawB   = press[2];
        downRawB = press[3];
        @(posedge clk1hz);
        pulse    = 4'b0000;
        inRepeat = 2'b00;
        for (int ch = 0; ch < 4; ch++) begin
            if (rst)            runLen[ch] = 0;
            else if (seen2[ch]) runLen[ch] = runLen[ch] + 1;
            else                runLen[ch] = 0;
`ifdef BUTTON_AUTOREPEAT_EN
            pulse[ch] = expPulse(runLen[ch], holdP[ch], repP[ch]);
            if (runLen[ch] >= 1 + holdP[ch]) inRepeat[ch / 2] = 1'b1;
`else
            pulse[ch] = expPulse(runLen[ch]);
`endif
            seen2[ch] = rst ? 1'b0 : seen1[ch];
            seen1[ch] = rst ? 1'b0 : press[ch];
        end
        expA = {pulse[0], pulse[1], inRepeat[0]};
        expB = {pulse[2], pulse[3], inRepeat[1]};
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b1);
            checkCount++;
            if ({upA, downA, holdA} !== 3'b000)
                $display("[TB] FAIL reset_A cycle %0d: got %b want 000", i, {upA, downA, holdA});
            else passCount++;
            checkCount++;
            if ({upB, downB, holdB} !== 3'b000)
                $display("[TB] FAIL reset_B cycle %0d: got %b want 000", i, {upB, downB, holdB});
            else passCount++;
        end
    endtask

    task automatic test_single_press();
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i < 10) ? 4'b0001 : 4'b0000, 1'b0);
            checkCount++;
            if ({upA, downA, holdA} !== expA)
                $display("[TB] FAIL single_press_A cycle %0d: got %b want %b", i, {upA, downA, holdA}, expA);
            else passCount++;
            checkCount++;
            if ({upB, downB, holdB} !== expB)
                $display("[TB] FAIL single_press_B cycle %0d: got %b want %b", i, {upB, downB, holdB}, expB);
            else passCount++;
        end
    endtask

    task automatic test_autorepeat();
        for (int i = 0; i < 18; i++) begin
            applyStimulus((i < 12) ? 4'b1010 : 4'b0000, 1'b0);
            checkCount++;
            if ({upA, downA, holdA} !== expA)
                $display("[TB] FAIL autorepeat_A cycle %0d: got %b want %b", i, {upA, downA, holdA}, expA);
            else passCount++;
            checkCount++;
            if ({upB, downB, holdB} !== expB)
                $display("[TB] FAIL autorepeat_B cycle %0d: got %b want %b", i, {upB, downB, holdB}, expB);
            else passCount++;
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i < 2) ? 4'b1111 : 4'b0000, 1'b0);
            checkCount++;
            if ({upA, downA, holdA} !== expA)
                $display("[TB] FAIL simultaneous_A cycle %0d: got %b want %b", i, {upA, downA, holdA}, expA);
            else passCount++;
            checkCount++;
            if ({upB, downB, holdB} !== expB)
                $display("[TB] FAIL simultaneous_B cycle %0d: got %b want %b", i, {upB, downB, holdB}, expB);
            else passCount++;
        end
    endtask

    task automatic test_reset_mid_repeat();
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i < 16) ? 4'b0110 : 4'b0000, (i == 8));
            checkCount++;
            if ({upA, downA, holdA} !== expA)
                $display("[TB] FAIL reset_mid_repeat_A cycle %0d: got %b want %b", i, {upA, downA, holdA}, expA);
            else passCount++;
            checkCount++;
            if ({upB, downB, holdB} !== expB)
                $display("[TB] FAIL reset_mid_repeat_B cycle %0d: got %b want %b", i, {upB, downB, holdB}, expB);
            else passCount++;
        end
    endtask

    task automatic test_glitch();
        logic [9:0] pattern;
        pattern = 10'b0000001101;
        for (int i = 0; i < 10; i++) begin
            applyStimulus({2'b00, pattern[i], pattern[i]} | {1'b0, pattern[i], 2'b00}, 1'b0);
            checkCount++;
            if ({upA, downA, holdA} !== expA)
                $display("[TB] FAIL glitch_A cycle %0d: got %b want %b", i, {upA, downA, holdA}, expA);
            else passCount++;
            checkCount++;
            if ({upB, downB, holdB} !== expB)
                $display("[TB] FAIL glitch_B cycle %0d: got %b want %b", i, {upB, downB, holdB}, expB);
            else passCount++;
        end
    endtask

    task automatic test_long_hold();
        for (int i = 0; i < 45; i++) begin
            applyStimulus((i < 40) ? 4'b1001 : 4'b0000, 1'b0);
            checkCount++;
            if ({upA, downA, holdA} !== expA)
                $display("[TB] FAIL long_hold_A cycle %0d: got %b want %b", i, {upA, downA, holdA}, expA);
            else passCount++;
            checkCount++;
            if ({upB, downB, holdB} !== expB)
                $display("[TB] FAIL long_hold_B cycle %0d: got %b want %b", i, {upB, downB, holdB}, expB);
            else passCount++;
        end
    endtask

    task automatic test_random();
        logic [3:0] press;
        logic       rst;
        press = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(0, 5) == 0) press[ch] = ~press[ch];
            rst = ($urandom_range(0, 39) == 0);
            applyStimulus(press, rst);
            checkCount++;
            if ({upA, downA, holdA} !== expA)
                $display("[TB] FAIL random_A cycle %0d: got %b want %b", i, {upA, downA, holdA}, expA);
            else passCount++;
            checkCount++;
            if ({upB, downB, holdB} !== expB)
                $display("[TB] FAIL random_B cycle %0d: got %b want %b", i, {upB, downB, holdB}, expB);
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_autorepeat();
        test_simultaneous();
        test_reset_mid_repeat();
        test_glitch();
        test_long_hold();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
